swap_req_scheduler: RTL and testbench

- Sits in front of the outbound swapper and shares its single request port among NUM_REQ page-eviction requesters.
- Arbitrates round-robin and holds each issued request until the swapper grants it.
- Tracks the pages currently being swapped out, up to MAX_OUTSTANDING, and throttles issue when that limit is reached.
- Absorbs duplicate requests for a page that is already in flight, so the page is never swapped out twice concurrently.

---
 rtl/swap_req_scheduler.sv | 154 +++++++++++++++
 tb/tb_swap_req_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swap_req_scheduler.sv
// Round-robin front end for the outbound swapper: tracks in-flight pages,
// throttles at MAX_OUTSTANDING and absorbs duplicate requests for a busy page.
module swap_req_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int PAGE_SIZE_WIDTH = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [64*NUM_REQ-1:0]                  req_vir_addr,
  output logic [NUM_REQ-1:0]                     req_grant,
  output logic                                   swp_req_valid,
  output logic [63:0]                            swp_req_vir_addr,
  input  logic                                   swp_req_grant,
  input  logic                                   swp_done,
  input  logic [63-PAGE_SIZE_WIDTH:0]            swp_done_page,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic [15:0]                            dup_drop_cnt,
  output logic                                   err_unmatched
);

  localparam int PW = 64 - PAGE_SIZE_WIDTH;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = $clog2(NUM_REQ);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                 state_reg;
  logic [IW-1:0]              last_winner_reg;
  logic [MAX_OUTSTANDING-1:0] ent_valid_reg;
  logic [PW-1:0]              ent_page_reg [MAX_OUTSTANDING];
  logic [CW-1:0]              outstanding_reg;
  logic [15:0]                dup_cnt_reg;
  logic                       err_reg;
  logic [63:0]                swp_addr_reg;

  logic [PW-1:0]                      req_page [NUM_REQ];
  logic [NUM_REQ*PAGE_SIZE_WIDTH-1:0] unused_low_bits;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_page[gi] = req_vir_addr[64*gi+PAGE_SIZE_WIDTH +: PW];
      assign unused_low_bits[gi*PAGE_SIZE_WIDTH +: PAGE_SIZE_WIDTH] =
        req_vir_addr[64*gi +: PAGE_SIZE_WIDTH];
    end
  endgenerate

  // Scan downward so the last hit is the first valid requester after last_winner.
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_pos;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_pos  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_sum = {1'b0, last_winner_reg} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NUM_REQ)) scan_sum = scan_sum - (IW+1)'(NUM_REQ);
      scan_pos = scan_sum[IW-1:0];
      if (req_valid[scan_pos]) begin
        win_found = 1'b1;
        win_idx   = scan_pos;
      end
    end
  end

  logic [PW-1:0]              win_page;
  logic [MAX_OUTSTANDING-1:0] dup_match;
  logic [MAX_OUTSTANDING-1:0] done_match;

  assign win_page = req_page[win_idx];

  generate
    for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_ent
      assign dup_match[gi]  = ent_valid_reg[gi] && (ent_page_reg[gi] == win_page);
      assign done_match[gi] = ent_valid_reg[gi] && (ent_page_reg[gi] == swp_done_page);
    end
  endgenerate

  logic                       can_issue;
  logic                       grant_fire;
  logic                       is_dup;
  logic                       insert_fire;
  logic                       done_hit;
  logic [MAX_OUTSTANDING-1:0] ins_mask;
  logic [MAX_OUTSTANDING-1:0] done_clear;

  assign can_issue   = (state_reg == IDLE) && (outstanding_reg != CW'(MAX_OUTSTANDING));
  assign grant_fire  = can_issue && win_found;
  assign is_dup      = |dup_match;
  assign insert_fire = (state_reg == HOLD) && swp_req_grant;
  assign done_hit    = swp_done && (|done_match);
  // Lowest clear bit of the valid vector picks the free slot.
  assign ins_mask    = insert_fire ? (~ent_valid_reg & (ent_valid_reg + 1'b1)) : '0;
  assign done_clear  = {MAX_OUTSTANDING{swp_done}} & done_match;

  always_comb begin
    req_grant = '0;
    if (grant_fire) req_grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      last_winner_reg <= IW'(NUM_REQ - 1);
      ent_valid_reg   <= '0;
      outstanding_reg <= '0;
      dup_cnt_reg     <= '0;
      err_reg         <= 1'b0;
      swp_addr_reg    <= '0;
    end else begin
      ent_valid_reg <= (ent_valid_reg & ~done_clear) | ins_mask;
      if (insert_fire && !done_hit)      outstanding_reg <= outstanding_reg + 1'b1;
      else if (!insert_fire && done_hit) outstanding_reg <= outstanding_reg - 1'b1;
      if (swp_done && !(|done_match)) err_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            last_winner_reg <= win_idx;
            if (is_dup) begin
              if (dup_cnt_reg != 16'hFFFF) dup_cnt_reg <= dup_cnt_reg + 16'd1;
            end else begin
              swp_addr_reg <= {win_page, {PAGE_SIZE_WIDTH{1'b0}}};
              state_reg    <= HOLD;
            end
          end
        end
        default: begin
          if (swp_req_grant) state_reg <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < MAX_OUTSTANDING; e++) begin
      if (ins_mask[e]) ent_page_reg[e] <= swp_addr_reg[63:PAGE_SIZE_WIDTH];
    end
  end

  assign swp_req_valid    = (state_reg == HOLD);
  assign swp_req_vir_addr = swp_addr_reg;
  assign outstanding      = outstanding_reg;
  assign dup_drop_cnt     = dup_cnt_reg;
  assign err_unmatched    = err_reg;

endmodule

// File: tb/tb_swap_req_scheduler.sv
// Bench for swap_req_scheduler: vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_swap_req_scheduler;

  localparam int N    = 4;
  localparam int PSW  = 16;
  localparam int MAXO = 4;
  localparam int PW   = 64 - PSW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [64*N-1:0] req_vir_addr;
  logic [N-1:0]    req_grant;
  logic            swp_req_valid;
  logic [63:0]     swp_req_vir_addr;
  logic            swp_req_grant;
  logic            swp_done;
  logic [PW-1:0]   swp_done_page;
  logic [2:0]      outstanding;
  logic [15:0]     dup_drop_cnt;
  logic            err_unmatched;

  always #5 clk = ~clk;

  swap_req_scheduler #(.NUM_REQ(N), .PAGE_SIZE_WIDTH(PSW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_vir_addr(req_vir_addr),
    .req_grant(req_grant), .swp_req_valid(swp_req_valid), .swp_req_vir_addr(swp_req_vir_addr),
    .swp_req_grant(swp_req_grant), .swp_done(swp_done), .swp_done_page(swp_done_page),
    .outstanding(outstanding), .dup_drop_cnt(dup_drop_cnt), .err_unmatched(err_unmatched)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: in-flight pages as a queue, plus the pending issue.
  logic [PW-1:0] m_pages[$];
  int            m_last;
  bit            m_hold;
  logic [63:0]   m_addr;
  int            m_dup;
  bit            m_err;
  bit            m_found;
  int            m_win;
  logic [N-1:0]  m_grant;

  task automatic model_reset();
    m_pages.delete();
    m_last  = N - 1;
    m_hold  = 0;
    m_addr  = '0;
    m_dup   = 0;
    m_err   = 0;
    m_found = 0;
    m_win   = 0;
    m_grant = '0;
  endtask

  task automatic model_check();
    m_found = 0;
    m_win   = 0;
    m_grant = '0;
    if (!m_hold && m_pages.size() < MAXO) begin
      for (int k = 1; k <= N; k++) begin
        int w;
        w = (m_last + k) % N;
        if (!m_found && req_valid[w]) begin
          m_found = 1;
          m_win   = w;
        end
      end
    end
    if (m_found) m_grant[m_win] = 1'b1;
    chk("m_req_grant", 64'(req_grant), 64'(m_grant));
    chk("m_swp_valid", 64'(swp_req_valid), 64'(m_hold));
    if (m_hold) chk("m_swp_addr", swp_req_vir_addr, m_addr);
    chk("m_outstanding", 64'(outstanding), 64'(m_pages.size()));
    chk("m_dup_cnt", 64'(dup_drop_cnt), 64'(m_dup));
    chk("m_err", 64'(err_unmatched), 64'(m_err));
  endtask

  task automatic model_update();
    bit            dup;
    int            hit;
    logic [PW-1:0] wp;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dup = 0;
    wp  = req_vir_addr[64*m_win+PSW +: PW];
    if (m_found) foreach (m_pages[j]) if (m_pages[j] == wp) dup = 1;
    if (swp_done) begin
      hit = -1;
      foreach (m_pages[j]) if (m_pages[j] == swp_done_page) hit = j;
      if (hit >= 0) m_pages.delete(hit);
      else m_err = 1;
    end
    if (m_hold && swp_req_grant) begin
      m_pages.push_back(m_addr[63:PSW]);
      m_hold = 0;
    end
    if (m_found) begin
      m_last = m_win;
      if (dup) begin
        if (m_dup < 65535) m_dup++;
      end else begin
        m_hold = 1;
        m_addr = {wp, 16'h0000};
      end
    end
  endtask

  task automatic step_begin();
    @(negedge clk);
    model_check();
  endtask

  task automatic step_end();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_addr(input int i, input logic [63:0] a);
    req_vir_addr[64*i +: 64] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; swp_req_grant = 1'b0; swp_done = 1'b0;
    step_begin(); step_end();
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic [N-1:0]  rv;
    logic          sg;
    logic          dn;
    logic [PW-1:0] dp;
    logic [N-1:0]  eg;
    logic          esv;
    logic [63:0]   ea;
    logic [2:0]    eo;
  } vec_t;

  vec_t vt[16];
  logic [N-1:0]  last_g;
  logic [PW-1:0] pool[6];

  initial begin
    rst_n = 1'b0; req_valid = '0; req_vir_addr = '0;
    swp_req_grant = 1'b0; swp_done = 1'b0; swp_done_page = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;

    step_begin();
    chk("rst_addr", swp_req_vir_addr, 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    step_end();

    // Single issue, full round-robin pass, throttle at full, release by done.
    set_addr(0, 64'h0000_1234_5678_9ABC);
    set_addr(1, 64'h0000_0000_0011_0100);
    set_addr(2, 64'h0000_0000_0022_0200);
    set_addr(3, 64'h0000_0000_0033_0300);
    vt[0]  = '{4'b0001, 1'b1, 1'b0, 48'h0, 4'b0001, 1'b0, 64'h0, 3'd0};
    vt[1]  = '{4'b0000, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_1234_5678_0000, 3'd0};
    vt[2]  = '{4'b0000, 1'b1, 1'b1, 48'h0000_1234_5678, 4'b0000, 1'b0, 64'h0, 3'd1};
    vt[3]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0010, 1'b0, 64'h0, 3'd0};
    vt[4]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_0000_0011_0000, 3'd0};
    vt[5]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0100, 1'b0, 64'h0, 3'd1};
    vt[6]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_0000_0022_0000, 3'd1};
    vt[7]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b1000, 1'b0, 64'h0, 3'd2};
    vt[8]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_0000_0033_0000, 3'd2};
    vt[9]  = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0001, 1'b0, 64'h0, 3'd3};
    vt[10] = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_1234_5678_0000, 3'd3};
    vt[11] = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b0, 64'h0, 3'd4};
    vt[12] = '{4'b1111, 1'b1, 1'b1, 48'h0000_0000_0011, 4'b0000, 1'b0, 64'h0, 3'd4};
    vt[13] = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0010, 1'b0, 64'h0, 3'd3};
    vt[14] = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b1, 64'h0000_0000_0011_0000, 3'd3};
    vt[15] = '{4'b1111, 1'b1, 1'b0, 48'h0, 4'b0000, 1'b0, 64'h0, 3'd4};
    for (int v = 0; v < 16; v++) begin
      req_valid = vt[v].rv; swp_req_grant = vt[v].sg;
      swp_done = vt[v].dn; swp_done_page = vt[v].dp;
      step_begin();
      chk($sformatf("vec%0d_grant", v), 64'(req_grant), 64'(vt[v].eg));
      chk($sformatf("vec%0d_swp_valid", v), 64'(swp_req_valid), 64'(vt[v].esv));
      if (vt[v].esv) chk($sformatf("vec%0d_addr", v), swp_req_vir_addr, vt[v].ea);
      chk($sformatf("vec%0d_outstanding", v), 64'(outstanding), 64'(vt[v].eo));
      step_end();
    end

    // Duplicate absorption.
    do_reset();
    swp_done_page = '0;
    set_addr(0, 64'h0000_0000_1234_0000); req_valid = 4'b0001; swp_req_grant = 1'b1;
    step_begin(); chk("dupA_grant0", 64'(req_grant), 64'(4'b0001)); step_end();
    req_valid = 4'b0000;
    step_begin(); chk("dupA_issue", swp_req_vir_addr, 64'h0000_0000_1234_0000); step_end();
    set_addr(2, 64'h0000_0000_1234_0040); req_valid = 4'b0100; swp_req_grant = 1'b0;
    step_begin(); chk("dup_grant2", 64'(req_grant), 64'(4'b0100)); step_end();
    req_valid = 4'b0000;
    step_begin();
    chk("dup_no_issue", 64'(swp_req_valid), 64'd0);
    chk("dup_cnt", 64'(dup_drop_cnt), 64'd1);
    chk("dup_outstanding", 64'(outstanding), 64'd1);
    step_end();

    // Unmatched done is sticky; done alongside an insert leaves the count unchanged.
    swp_done = 1'b1; swp_done_page = 48'h9999;
    step_begin(); chk("err_before", 64'(err_unmatched), 64'd0); step_end();
    swp_done = 1'b0;
    step_begin(); chk("err_set", 64'(err_unmatched), 64'd1); step_end();
    step_begin(); chk("err_sticky", 64'(err_unmatched), 64'd1); step_end();
    set_addr(1, 64'h0000_0000_5555_0000); req_valid = 4'b0010;
    step_begin(); chk("same_grant1", 64'(req_grant), 64'(4'b0010)); step_end();
    req_valid = 4'b0000; swp_req_grant = 1'b1; swp_done = 1'b1; swp_done_page = 48'h1234;
    step_begin(); chk("same_hold", 64'(swp_req_valid), 64'd1); step_end();
    swp_req_grant = 1'b0; swp_done = 1'b0;
    step_begin(); chk("same_outstanding", 64'(outstanding), 64'd1); step_end();

    // Reset while holding discards the request and empties the table.
    set_addr(3, 64'h0000_0000_7777_0000); req_valid = 4'b1000;
    step_begin(); chk("rstH_grant3", 64'(req_grant), 64'(4'b1000)); step_end();
    req_valid = 4'b0000;
    step_begin(); chk("rstH_hold", 64'(swp_req_valid), 64'd1); step_end();
    rst_n = 1'b0;
    step_begin(); step_end();
    rst_n = 1'b1;
    step_begin();
    chk("rstH_valid", 64'(swp_req_valid), 64'd0);
    chk("rstH_outstanding", 64'(outstanding), 64'd0);
    chk("rstH_err", 64'(err_unmatched), 64'd0);
    chk("rstH_dup", 64'(dup_drop_cnt), 64'd0);
    chk("rstH_addr", swp_req_vir_addr, 64'h0);
    step_end();
    req_valid = 4'b1000;
    step_begin(); chk("rstH_regrant", 64'(req_grant), 64'(4'b1000)); step_end();
    req_valid = 4'b0000; swp_req_grant = 1'b1;
    step_begin();
    chk("rstH_reissue", 64'(swp_req_valid), 64'd1);
    chk("rstH_readdr", swp_req_vir_addr, 64'h0000_0000_7777_0000);
    step_end();
    swp_req_grant = 1'b0;
    step_begin(); chk("rstH_out1", 64'(outstanding), 64'd1); step_end();

    // Random traffic against the model; a small page pool forces duplicates.
    pool[0] = 48'h1234; pool[1] = 48'h5555; pool[2] = 48'h7777;
    pool[3] = 48'h0ABC; pool[4] = 48'h9000; pool[5] = 48'h0042;
    do_reset();
    last_g = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_g[i]) begin
          if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
          else set_addr(i, {pool[$urandom_range(5, 0)], 16'($urandom)});
        end else if (!req_valid[i] && $urandom_range(9, 0) < 4) begin
          req_valid[i] = 1'b1;
          set_addr(i, {pool[$urandom_range(5, 0)], 16'($urandom)});
        end
      end
      swp_req_grant = ($urandom_range(9, 0) < 6);
      begin
        int r;
        r = $urandom_range(99, 0);
        if (r < 30 && m_pages.size() > 0) begin
          swp_done = 1'b1;
          swp_done_page = m_pages[$urandom_range(m_pages.size() - 1, 0)];
        end else if (r >= 98) begin
          swp_done = 1'b1;
          swp_done_page = 48'hDEAD;
        end else begin
          swp_done = 1'b0;
        end
      end
      rst_n = ($urandom_range(499, 0) != 0);
      step_begin();
      last_g = m_grant;
      step_end();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
